// File: rtl/rambus_pkg.sv
// Shared types and constants for the APB-to-RamBus bridge.
package rambus_pkg;

  localparam int RB_ADDR_W = 14;
  localparam int RB_DATA_W = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    ERR
  } rb_state_t;

endpackage

// File: rtl/rb_timeout_counter.sv
// Clear/enable cycle counter; o_tc flags the terminal count TIMEOUT_CYCLES-1.
module rb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/apb_rambus_bridge.sv
// APB slave to RamBus register bridge: one outstanding access, registered
// handshake, single-cycle latch strobe, ack timeout and saturating error count.
module apb_rambus_bridge
  import rambus_pkg::*;
#(
  parameter int ADDR_W         = RB_ADDR_W,
  parameter int DATA_W         = RB_DATA_W,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDR_W-1:0]    paddr,
  input  logic [DATA_W-1:0]    pwdata,
  output logic [DATA_W-1:0]    prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic                 rb_ncs,
  output logic                 rb_wrnrd,
  output logic                 rb_latch,
  output logic [ADDR_W-1:0]    rb_addr,
  output logic [DATA_W-1:0]    rb_wdata,
  input  logic [DATA_W-1:0]    rb_rdata,
  input  logic                 rb_ack,
  output logic [ERR_CNT_W-1:0] err_count
);

  rb_state_t r_state, w_next;

  logic                 w_setup, w_misaligned, w_ack, w_abort;
  logic                 w_cnt_clr, w_cnt_en, w_tc, w_err_inc;
  logic                 r_ack_pend;
  logic [DATA_W-1:0]    r_rdata_pend;
  logic [DATA_W-1:0]    r_prdata, r_wdata;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_pready, r_pslverr, r_ncs, r_wrnrd, r_latch;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign w_setup      = psel && !penable;
  assign w_misaligned = (paddr[1:0] & ALIGN_MASK) != 2'b00;
  assign w_ack        = rb_ack || r_ack_pend;
  assign w_err_inc    = w_abort || (r_state == ERR);

  rb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk(clk),
    .i_rst(rst),
    .i_clr(w_cnt_clr),
    .i_en (w_cnt_en),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_abort   = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (r_state)
      IDLE:  if (w_setup) w_next = w_misaligned ? ERR : ISSUE;
      ISSUE: begin
        w_cnt_clr = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        if (w_ack) begin
          w_next = RESP;
        end else if (!psel) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (w_tc) begin
          w_next = ERR;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      RESP:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prdata     <= '0;
      r_pready     <= 1'b0;
      r_pslverr    <= 1'b0;
      r_ncs        <= 1'b1;
      r_wrnrd      <= 1'b0;
      r_latch      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err_cnt    <= '0;
      r_ack_pend   <= 1'b0;
      r_rdata_pend <= '0;
    end else begin
      r_latch   <= (w_next == ISSUE);
      r_ncs     <= !((w_next == ISSUE) || (w_next == WAIT));
      r_pready  <= (w_next == RESP) || (w_next == ERR);
      r_pslverr <= (w_next == ERR);
      if (r_state == IDLE && w_setup) begin
        r_addr  <= paddr;
        r_wdata <= pwdata;
        r_wrnrd <= pwrite;
      end
      // An ack seen during ISSUE is held over and consumed in the first WAIT cycle.
      r_ack_pend <= (r_state == ISSUE) && rb_ack;
      if (r_state == ISSUE) r_rdata_pend <= rb_rdata;
      if (r_state == WAIT && w_ack && !r_wrnrd) begin
        r_prdata <= r_ack_pend ? r_rdata_pend : rb_rdata;
      end
      if (w_err_inc && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign prdata    = r_prdata;
  assign pready    = r_pready;
  assign pslverr   = r_pslverr;
  assign rb_ncs    = r_ncs;
  assign rb_wrnrd  = r_wrnrd;
  assign rb_latch  = r_latch;
  assign rb_addr   = r_addr;
  assign rb_wdata  = r_wdata;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_apb_rambus_bridge.sv
// Scoreboard bench: instance a uses the default timeout, instance b a 4-cycle timeout.
module tb_apb_rambus_bridge;

  typedef struct {
    int          dut;
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int          dut;
    int          cyc;
    logic        wr;
    logic [13:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel_a, psel_b, penable, pwrite, rb_ack;
  logic [13:0] paddr;
  logic [31:0] pwdata, rb_rdata;

  logic [31:0] prdata_a, prdata_b, rb_wdata_a, rb_wdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  logic        rb_ncs_a, rb_ncs_b, rb_wrnrd_a, rb_wrnrd_b, rb_latch_a, rb_latch_b;
  logic [13:0] rb_addr_a, rb_addr_b;
  logic [7:0]  err_count_a, err_count_b;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  resp_t       resp_q[$];
  cmd_t        cmd_q[$];
  logic [31:0] model_prd[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_rambus_bridge u_dut_a (
    .clk(clk), .rst(rst), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
    .pslverr(pslverr_a), .rb_ncs(rb_ncs_a), .rb_wrnrd(rb_wrnrd_a),
    .rb_latch(rb_latch_a), .rb_addr(rb_addr_a), .rb_wdata(rb_wdata_a),
    .rb_rdata(rb_rdata), .rb_ack(rb_ack), .err_count(err_count_a)
  );

  apb_rambus_bridge #(.TIMEOUT_CYCLES(4)) u_dut_b (
    .clk(clk), .rst(rst), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .rb_ncs(rb_ncs_b), .rb_wrnrd(rb_wrnrd_b),
    .rb_latch(rb_latch_b), .rb_addr(rb_addr_b), .rb_wdata(rb_wdata_b),
    .rb_rdata(rb_rdata), .rb_ack(rb_ack), .err_count(err_count_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_resp(input int d, input logic se, input logic [31:0] pd, input logic ncs);
    resp_t r;
    if (resp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_pready: dut%0d got pready=1 expected none (cycle %0d)", d, cyc);
    end else begin
      r = resp_q.pop_front();
      chk("resp_dut", 64'(d), 64'(r.dut));
      chk("pready_cycle", 64'(cyc), 64'(r.cyc));
      chk("pslverr", 64'(se), 64'(r.err));
      chk("prdata", 64'(pd), 64'(r.rdata));
      chk("ncs_at_pready", 64'(ncs), 64'(1));
      chk("penable_at_pready", 64'(penable), 64'(1));
    end
  endtask

  task automatic mon_cmd(input int d, input logic wr, input logic [13:0] ad,
                         input logic [31:0] wd, input logic ncs);
    cmd_t c;
    if (cmd_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_latch: dut%0d got rb_latch=1 expected none (cycle %0d)", d, cyc);
    end else begin
      c = cmd_q.pop_front();
      chk("latch_dut", 64'(d), 64'(c.dut));
      chk("latch_cycle", 64'(cyc), 64'(c.cyc));
      chk("rb_wrnrd", 64'(wr), 64'(c.wr));
      chk("rb_addr", 64'(ad), 64'(c.addr));
      chk("rb_wdata", 64'(wd), 64'(c.wdata));
      chk("ncs_at_latch", 64'(ncs), 64'(0));
    end
  endtask

  always @(negedge clk) begin
    if (pready_a === 1'b1) mon_resp(0, pslverr_a, prdata_a, rb_ncs_a);
    if (pready_b === 1'b1) mon_resp(1, pslverr_b, prdata_b, rb_ncs_b);
    if (rb_latch_a === 1'b1) mon_cmd(0, rb_wrnrd_a, rb_addr_a, rb_wdata_a, rb_ncs_a);
    if (rb_latch_b === 1'b1) mon_cmd(1, rb_wrnrd_b, rb_addr_b, rb_wdata_b, rb_ncs_b);
  end

  task automatic chk_reset(input string tag, input logic [31:0] pd, input logic prdy,
                           input logic se, input logic ncs, input logic wr, input logic lat,
                           input logic [13:0] ad, input logic [31:0] wd, input logic [7:0] ec);
    chk({tag, "_prdata"}, 64'(pd), 64'(0));
    chk({tag, "_pready"}, 64'(prdy), 64'(0));
    chk({tag, "_pslverr"}, 64'(se), 64'(0));
    chk({tag, "_rb_ncs"}, 64'(ncs), 64'(1));
    chk({tag, "_rb_wrnrd"}, 64'(wr), 64'(0));
    chk({tag, "_rb_latch"}, 64'(lat), 64'(0));
    chk({tag, "_rb_addr"}, 64'(ad), 64'(0));
    chk({tag, "_rb_wdata"}, 64'(wd), 64'(0));
    chk({tag, "_err_count"}, 64'(ec), 64'(0));
  endtask

  // One APB access; ack_k = cycles after ISSUE that rb_ack pulses (-1: never).
  task automatic do_access(input int d, input logic wr, input logic [13:0] addr,
                           input logic [31:0] wd, input int ack_k, input logic [31:0] rd,
                           input logic exp_err, input int exp_lat);
    int    c0;
    int    i;
    bit    seen;
    resp_t r;
    cmd_t  c;
    @(posedge clk); #1;
    c0 = cyc;
    if (d == 0) psel_a = 1'b1; else psel_b = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    if (addr[1:0] == 2'b00) begin
      c.dut = d; c.cyc = c0 + 1; c.wr = wr; c.addr = addr; c.wdata = wd;
      cmd_q.push_back(c);
    end
    if (!exp_err && !wr) model_prd[d] = rd;
    r.dut = d; r.cyc = c0 + exp_lat; r.err = exp_err; r.rdata = model_prd[d];
    resp_q.push_back(r);
    seen = 1'b0;
    i = 0;
    while (!seen && i < 60) begin
      i++;
      @(posedge clk); #1;
      penable  = 1'b1;
      rb_ack   = (ack_k >= 0) && (i == ack_k + 1);
      rb_rdata = rb_ack ? rd : 32'hDEAD_BEEF;
      @(negedge clk);
      seen = (d == 0) ? pready_a : pready_b;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL no_pready: dut%0d addr %0h got no pready expected one within 60 cycles", d, addr);
    end
    @(posedge clk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; rb_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected one before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   c0;
    cmd_t c;
    rst = 1'b1; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; rb_rdata = '0; rb_ack = 1'b0;
    model_prd[0] = '0; model_prd[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst_a", prdata_a, pready_a, pslverr_a, rb_ncs_a, rb_wrnrd_a, rb_latch_a,
              rb_addr_a, rb_wdata_a, err_count_a);
    chk_reset("rst_b", prdata_b, pready_b, pslverr_b, rb_ncs_b, rb_wrnrd_b, rb_latch_b,
              rb_addr_b, rb_wdata_b, err_count_b);
    @(posedge clk); #1 rst = 1'b0;

    // aligned write, ack in first WAIT -> pready at T3, prdata still reset value
    do_access(0, 1'b1, 14'h0010, 32'hA5A5_1234, 1, 32'h0, 1'b0, 3);
    // aligned read, ack 5 cycles after ISSUE -> pready at T7
    do_access(0, 1'b0, 14'h0124, 32'h0, 5, 32'hCAFE_F00D, 1'b0, 7);
    // write after read keeps prdata at 0xCAFEF00D
    do_access(0, 1'b1, 14'h0014, 32'h5A5A_0000, 1, 32'h0, 1'b0, 3);
    // misaligned: error at T1, no RamBus cycle
    do_access(0, 1'b1, 14'h0002, 32'h0, -1, 32'h0, 1'b1, 1);
    chk("errcnt_misaligned", 64'(err_count_a), 64'(1));

    // master abort: psel drops in the second WAIT cycle
    @(posedge clk); #1;
    c0 = cyc;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 14'h0040; pwdata = 32'h0;
    c.dut = 0; c.cyc = c0 + 1; c.wr = 1'b0; c.addr = 14'h0040; c.wdata = 32'h0;
    cmd_q.push_back(c);
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 psel_a = 1'b0; penable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("errcnt_abort", 64'(err_count_a), 64'(2));
    chk("ncs_after_abort", 64'(rb_ncs_a), 64'(1));

    // reset during WAIT of a write
    @(posedge clk); #1;
    c0 = cyc;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 14'h0200; pwdata = 32'h1111_2222;
    c.dut = 0; c.cyc = c0 + 1; c.wr = 1'b1; c.addr = 14'h0200; c.wdata = 32'h1111_2222;
    cmd_q.push_back(c);
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst_wait_a", prdata_a, pready_a, pslverr_a, rb_ncs_a, rb_wrnrd_a, rb_latch_a,
              rb_addr_a, rb_wdata_a, err_count_a);
    @(posedge clk); #1;
    rst = 1'b0; psel_a = 1'b0; penable = 1'b0; pwrite = 1'b0;
    model_prd[0] = '0;

    // error counter saturation
    for (int k = 0; k < 260; k++) begin
      do_access(0, 1'b0, 14'((k * 4) + 1 + (k % 3)), 32'h0, -1, 32'h0, 1'b1, 1);
      if (k == 253) chk("errcnt_254", 64'(err_count_a), 64'(8'hFE));
      if (k == 254) chk("errcnt_255", 64'(err_count_a), 64'(8'hFF));
    end
    chk("errcnt_saturated", 64'(err_count_a), 64'(8'hFF));
    do_access(0, 1'b0, 14'h0300, 32'h0, 2, 32'h0BAD_C0DE, 1'b0, 4);
    chk("errcnt_after_ok", 64'(err_count_a), 64'(8'hFF));

    // timeout on the 4-cycle instance, then a normal read acked during ISSUE
    do_access(1, 1'b0, 14'h0080, 32'h0, -1, 32'h0, 1'b1, 6);
    chk("errcnt_timeout", 64'(err_count_b), 64'(1));
    do_access(1, 1'b0, 14'h0084, 32'h0, 0, 32'h1357_9BDF, 1'b0, 3);
    chk("errcnt_after_timeout", 64'(err_count_b), 64'(1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("resp_queue_drained", 64'(resp_q.size()), 64'(0));
    chk("cmd_queue_drained", 64'(cmd_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_rambus_bridge.md
Name: apb_rambus_bridge

Overview:
- Converts one MSS APB slave port (FIC_0 AMBA_SLAVE_0 or AMBA_SLAVE_0_1) into the fabric RamBus register protocol consumed by DMMainPorts.
- Sits between the MSS and DMMainPorts, and instantiates once per RamBus channel.
- Replaces direct PSEL/PENABLE/PREADY wiring with a registered handshake, a single-cycle latch strobe and an ack timeout.
- Adds alignment and timeout error reporting on PSLVERR, plus a saturating error counter.

Parameters:
ADDR_W, 14, RamBus address width; taken from PADDR[ADDR_W-1:0].
DATA_W, 32, APB/RamBus data width.
TIMEOUT_CYCLES, 255, WAIT cycles without rb_ack before the access is failed; legal range 2..65535.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  fabric clock (FCCC GL0), shared with MSS CLK0.
rst  in  1  synchronous, active-high reset.
psel  in  1  APB select.
penable  in  1  APB enable (access phase).
pwrite  in  1  APB direction; 1 = write.
paddr  in  ADDR_W  APB byte address.
pwdata  in  DATA_W  APB write data.
prdata  out  DATA_W  APB read data, registered.
pready  out  1  APB ready, registered.
pslverr  out  1  APB error, registered; valid only with pready.
rb_ncs  out  1  RamBus chip select, active low.
rb_wrnrd  out  1  RamBus direction; 1 = write.
rb_latch  out  1  RamBus single-cycle command strobe.
rb_addr  out  ADDR_W  RamBus address; held for the whole transaction.
rb_wdata  out  DATA_W  RamBus write data; held for the whole transaction.
rb_rdata  in  DATA_W  RamBus read data; sampled on rb_ack.
rb_ack  in  1  RamBus completion; may assert any cycle from ISSUE onward.
err_count  out  ERR_CNT_W  saturating count of errored or aborted transactions.

Behaviour:
- Reset values: state=IDLE, prdata=0, pready=0, pslverr=0, rb_ncs=1, rb_wrnrd=0, rb_latch=0, rb_addr=0, rb_wdata=0, err_count=0, timeout counter=0.
- Reset asserted in any state forces these values on the next edge. Any in-flight RamBus access is abandoned, with no pready.
- FSM states and transitions:
  - IDLE: on psel & !penable (APB setup), capture paddr, pwdata and pwrite into rb_addr, rb_wdata and rb_wrnrd.
    - If paddr[1:0] != 0, go to ERR; no RamBus cycle is issued.
    - Otherwise go to ISSUE.
    - psel & penable seen in IDLE (protocol violation) is ignored.
  - ISSUE: rb_ncs=0, rb_latch=1 for exactly this cycle, timeout counter cleared. Go to WAIT.
  - WAIT: rb_ncs=0, rb_latch=0.
    - rb_ack=1: on a read, prdata<=rb_rdata; go to RESP.
    - Else if psel=0 (master abort): rb_ncs<=1, err_count++, go to IDLE with no pready.
    - Else if counter==TIMEOUT_CYCLES-1: go to ERR.
    - Else counter++.
  - rb_ack during ISSUE is registered and treated as ack in the first WAIT cycle.
  - RESP: pready=1, pslverr=0 for exactly one cycle; rb_ncs=1. Go to IDLE.
  - ERR: pready=1, pslverr=1 for exactly one cycle, prdata unchanged, rb_ncs=1, err_count++. Go to IDLE.
- Latency: setup at T0, ISSUE at T1, earliest WAIT ack at T2, pready at T3. A misaligned access gives pready/pslverr at T1.
- Back-to-back: a new setup is accepted in the cycle after RESP/ERR (IDLE). There is no pipelining; only one outstanding access.
- err_count saturates at all-ones and never wraps.
- On a write, prdata is held from the last read.
- pready is never asserted while penable=0.

Decomposition:
- Shared package rambus_pkg holds:
  - typedef rb_state_t {IDLE, ISSUE, WAIT, RESP, ERR};
  - constants RB_ADDR_W=14 and RB_DATA_W=32;
  - ALIGN_MASK=2'b11.
- One sub-module, rb_timeout_counter: a clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES-1.

Test Plan:
- Aligned write: paddr=0x0010, pwdata=0xA5A5_1234, rb_ack at the first WAIT cycle -> rb_latch is high for 1 cycle at T1 with rb_wrnrd=1 and rb_addr=0x0010; pready=1 and pslverr=0 at T3; rb_ncs returns to 1 at T3.
- Aligned read: paddr=0x0124, rb_rdata=0xCAFE_F00D, rb_ack 5 cycles after ISSUE -> prdata=0xCAFE_F00D in the pready cycle; pslverr=0.
- Misaligned: paddr=0x0002 -> no rb_latch and rb_ncs stays 1; pready=1 and pslverr=1 at T1; err_count goes 0->1.
- Timeout: TIMEOUT_CYCLES=4, rb_ack held low -> ERR after 4 WAIT cycles, pslverr=1, err_count increments. Then issue a second access with ack -> it completes normally.
- Abort and reset: drop psel during WAIT -> IDLE, no pready, err_count +1. Assert rst during WAIT of another access -> all outputs return to reset values on the next edge.
- Saturation: force 260 misaligned accesses with ERR_CNT_W=8 -> err_count=0xFF and stays there.
